vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The module SHALL have parameter CW, default 11: width of the x/y coordinate outputs and internal counters.
REQ-002 The module SHALL have parameters H_ACTIVE 640, H_FP 16, H_SYNC 96, H_BP 48: horizontal visible, front-porch, sync and back-porch lengths in pixels.
REQ-003 The module SHALL have parameters V_ACTIVE 480, V_FP 10, V_SYNC 2, V_BP 33: vertical visible, front-porch, sync and back-porch lengths in lines.
REQ-004 The module SHALL have parameters HS_POL 0 and VS_POL 0: active level of HS and VS.
REQ-005 The module SHALL have parameter FW, default 16: frame counter width.
REQ-006 pixel_clk  in  1  pixel clock; all logic rising-edge.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 en  in  1  scan enable; start/stop requests honoured only at frame boundaries.
REQ-009 HS, VS  out  1 each  sync outputs.
REQ-010 de  out  1  data enable; high in the visible region.
REQ-011 x, y  out  CW each  current pixel coordinates.
REQ-012 line_start, frame_start  out  1 each  single-cycle pulses.
REQ-013 frame_cnt  out  FW  completed-frame count.
REQ-014 running  out  1  high while in RUN or STOP.

Function
REQ-015 The module SHALL derive H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL likewise; the h counter SHALL run 0..H_TOTAL-1, and the v counter 0..V_TOTAL-1, advancing when h = H_TOTAL-1 (exactly H_TOTAL cycles per line, never H_TOTAL+1).
REQ-016 The FSM SHALL have states IDLE, RUN and STOP; IDLE with en=1 goes to RUN on the next edge with h=v=0.
REQ-017 In RUN, en=0 SHALL go to STOP; STOP SHALL keep scanning, return to RUN if en=1, and go to IDLE on the edge after h=H_TOTAL-1, v=V_TOTAL-1.
REQ-018 RUN with en=1 at the last pixel SHALL wrap both counters to 0 without a gap cycle.
REQ-019 In IDLE, counters SHALL hold 0, de=0, HS=!HS_POL, VS=!VS_POL, pulses low, and running=0.
REQ-020 All outputs SHALL be registered from the same counter state, giving 1-cycle latency from counters and no relative skew between HS, VS, de, x and y.
REQ-021 HS SHALL equal HS_POL when h is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), else !HS_POL; VS SHALL follow the same rule on v with the V_* parameters.
REQ-022 de SHALL equal (h<H_ACTIVE && v<V_ACTIVE); x and y SHALL equal h and v during RUN/STOP.
REQ-023 line_start SHALL pulse when h=0, and frame_start SHALL pulse when h=0 and v=0, in RUN/STOP only.
REQ-024 frame_cnt SHALL increment by 1 on each completed last pixel and wrap modulo 2^FW.
REQ-025 Totals SHALL fit in CW bits; an elaboration-time check SHALL fail otherwise.

Reset
REQ-026 Asserting rst_n low SHALL immediately force IDLE, h=v=0, frame_cnt=0, de=0, pulses=0, running=0, HS=!HS_POL, VS=!VS_POL, x=y=0, including mid-frame.
REQ-027 After rst_n deassertion, the first RUN cycle SHALL start at h=v=0 only when en=1.

Structure
REQ-028 Shared package vga_pkg SHALL hold the 640x480@60 timing constants, the FSM state enumeration, and the frame-end helper constant definitions.
REQ-029 One sub-module, vga_axis_counter (parametrised wrap counter with terminal-count output), SHALL be instantiated twice (h, v).

Verification
REQ-030 Default parameters, en=1 from reset release: verify 800 cycles between line_start pulses, 420000 between frame_start pulses, HS low for exactly 96 cycles starting at x=656.
REQ-031 Default parameters: de high exactly 640x480=307200 cycles per frame; VS low during y=490..491 only.
REQ-032 Deassert en at y=100: scanning continues to x=799,y=524, frame_cnt increments by 1, then IDLE with running=0 and HS/VS high.
REQ-033 Deassert en then reassert at y=300 of the same frame: no IDLE entry, frame_start next at the normal 420000-cycle spacing.
REQ-034 Pulse rst_n low at x=500,y=200: outputs reach reset values within the same cycle; with en held 1, scan restarts at x=y=0.
REQ-035 FW=2 with 5 frames: frame_cnt sequence is 1,2,3,0,1.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing definitions: 640x480@60 constants, scan FSM states and
// helpers for line/frame terminal detection.
package vga_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;

  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } vga_state_e;

  function automatic int axis_total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

  // Index of the last position on an axis; a frame ends where both axes sit on theirs.
  function automatic int axis_last(input int total);
    return total - 1;
  endfunction

  function automatic logic is_frame_end(input logic h_tc, input logic v_tc);
    return h_tc & v_tc;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Wrap-around position counter for one scan axis with a terminal-count flag.
module vga_axis_counter #(
  parameter int CW    = 11,
  parameter int TOTAL = 800
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  input  logic          inc_i,
  output logic [CW-1:0] cnt_o,
  output logic          tc_o
);

  localparam logic [CW-1:0] LAST = CW'(vga_pkg::axis_last(TOTAL));

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tc_o  = (cnt_q == LAST);
  assign cnt_o = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = tc_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: h/v scan counters, start/stop FSM honouring
// frame boundaries, and sync/enable/coordinate outputs registered together.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int CW       = 11,
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int FW       = 16
) (
  input  logic          pixel_clk,
  input  logic          rst_n,
  input  logic          en,
  output logic          HS,
  output logic          VS,
  output logic          de,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start,
  output logic [FW-1:0] frame_cnt,
  output logic          running
);

  localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  if ((longint'(H_TOTAL) > (longint'(1) << CW)) || (longint'(V_TOTAL) > (longint'(1) << CW))) begin : g_size_check
    $error("vga_timing_gen: H_TOTAL/V_TOTAL do not fit in CW bits");
  end

  // One extra bit so region bounds equal to 2**CW still compare correctly.
  localparam logic [CW:0] H_DE_END   = (CW+1)'(H_ACTIVE);
  localparam logic [CW:0] H_SYNC_BEG = (CW+1)'(H_ACTIVE + H_FP);
  localparam logic [CW:0] H_SYNC_END = (CW+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW:0] V_DE_END   = (CW+1)'(V_ACTIVE);
  localparam logic [CW:0] V_SYNC_BEG = (CW+1)'(V_ACTIVE + V_FP);
  localparam logic [CW:0] V_SYNC_END = (CW+1)'(V_ACTIVE + V_FP + V_SYNC);

  vga_state_e    state_q;
  logic [CW-1:0] h_cnt;
  logic [CW-1:0] v_cnt;
  logic          h_tc;
  logic          v_tc;
  logic          scanning;
  logic          frame_end;
  logic          in_hsync;
  logic          in_vsync;
  logic          in_active;

  logic          hs_q;
  logic          vs_q;
  logic          de_q;
  logic [CW-1:0] x_q;
  logic [CW-1:0] y_q;
  logic          ls_q;
  logic          fs_q;
  logic [FW-1:0] fc_q;
  logic          run_q;

  assign scanning  = (state_q != ST_IDLE);
  assign frame_end = scanning && is_frame_end(h_tc, v_tc);

  vga_axis_counter #(
    .CW    (CW),
    .TOTAL (H_TOTAL)
  ) u_h_cnt (
    .clk_i  (pixel_clk),
    .rst_ni (rst_n),
    .clr_i  (!scanning),
    .inc_i  (scanning),
    .cnt_o  (h_cnt),
    .tc_o   (h_tc)
  );

  vga_axis_counter #(
    .CW    (CW),
    .TOTAL (V_TOTAL)
  ) u_v_cnt (
    .clk_i  (pixel_clk),
    .rst_ni (rst_n),
    .clr_i  (!scanning),
    .inc_i  (scanning && h_tc),
    .cnt_o  (v_cnt),
    .tc_o   (v_tc)
  );

  assign in_hsync  = ({1'b0, h_cnt} >= H_SYNC_BEG) && ({1'b0, h_cnt} < H_SYNC_END);
  assign in_vsync  = ({1'b0, v_cnt} >= V_SYNC_BEG) && ({1'b0, v_cnt} < V_SYNC_END);
  assign in_active = ({1'b0, h_cnt} < H_DE_END) && ({1'b0, v_cnt} < V_DE_END);

  // Every output is a registered function of the same (state, h, v) snapshot.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      hs_q    <= ~HS_POL;
      vs_q    <= ~VS_POL;
      de_q    <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
      fc_q    <= '0;
      run_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (en) state_q <= ST_RUN;
        ST_RUN:  if (!en) state_q <= ST_STOP;
        ST_STOP: begin
          if (en) begin
            state_q <= ST_RUN;
          end else if (frame_end) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      if (frame_end) begin
        fc_q <= fc_q + 1'b1;
      end

      hs_q  <= (scanning && in_hsync) ? HS_POL : ~HS_POL;
      vs_q  <= (scanning && in_vsync) ? VS_POL : ~VS_POL;
      de_q  <= scanning && in_active;
      x_q   <= scanning ? h_cnt : '0;
      y_q   <= scanning ? v_cnt : '0;
      ls_q  <= scanning && (h_cnt == '0);
      fs_q  <= scanning && (h_cnt == '0) && (v_cnt == '0);
      run_q <= scanning;
    end
  end

  assign HS          = hs_q;
  assign VS          = vs_q;
  assign de          = de_q;
  assign x           = x_q;
  assign y           = y_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;
  assign frame_cnt   = fc_q;
  assign running     = run_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a reduced-raster instance checked every cycle against
// a linear-position model, plus a default 640x480 instance checked over one line.
module tb_vga_timing_gen;

  localparam int S_HA = 8, S_HF = 2, S_HS = 3, S_HB = 2;
  localparam int S_VA = 6, S_VF = 1, S_VS = 2, S_VB = 1;
  localparam int S_HT = S_HA + S_HF + S_HS + S_HB;
  localparam int S_VT = S_VA + S_VF + S_VS + S_VB;
  localparam int S_FT = S_HT * S_VT;
  localparam int SCW  = 6;
  localparam int SFW  = 2;
  localparam int VW   = 2 * SCW + SFW + 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0, rst_n_d = 1'b0, en_s = 1'b0, en_d = 1'b1;

  logic s_hs, s_vs, s_de, s_ls, s_fs, s_run;
  logic [SCW-1:0] s_x, s_y;
  logic [SFW-1:0] s_fc;
  logic d_hs, d_vs, d_de, d_ls, d_fs, d_run;
  logic [10:0] d_x, d_y;
  logic [15:0] d_fc;

  int errors = 0;
  int checks = 0;
  int cyc_cnt = 0;
  int run_low_cnt = 0;
  bit d_done = 1'b0;

  vga_timing_gen #(
    .CW(SCW), .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
    .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
    .HS_POL(1'b0), .VS_POL(1'b0), .FW(SFW)
  ) dut_s (
    .pixel_clk(clk), .rst_n(rst_n), .en(en_s), .HS(s_hs), .VS(s_vs), .de(s_de),
    .x(s_x), .y(s_y), .line_start(s_ls), .frame_start(s_fs), .frame_cnt(s_fc),
    .running(s_run)
  );

  vga_timing_gen dut_d (
    .pixel_clk(clk), .rst_n(rst_n_d), .en(en_d), .HS(d_hs), .VS(d_vs), .de(d_de),
    .x(d_x), .y(d_y), .line_start(d_ls), .frame_start(d_fs), .frame_cnt(d_fc),
    .running(d_run)
  );

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;
  always @(negedge clk) if (rst_n && !s_run) run_low_cnt <= run_low_cnt + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected outputs for a scan position, derived purely from the raster rules.
  function automatic logic [VW-1:0] expect_vec(input int mode, input int pos, input int fc);
    int h, v;
    logic hs, vs, de, ls, fs, run;
    logic [SCW-1:0] xx, yy;
    if (mode == 0) begin
      hs = 1'b1; vs = 1'b1; de = 1'b0; ls = 1'b0; fs = 1'b0; run = 1'b0; xx = '0; yy = '0;
    end else begin
      h   = pos % S_HT;
      v   = pos / S_HT;
      hs  = !(h >= S_HA + S_HF && h < S_HA + S_HF + S_HS);
      vs  = !(v >= S_VA + S_VF && v < S_VA + S_VF + S_VS);
      de  = (h < S_HA) && (v < S_VA);
      ls  = (h == 0);
      fs  = (pos == 0);
      run = 1'b1;
      xx  = SCW'(h);
      yy  = SCW'(v);
    end
    return {hs, vs, de, ls, fs, run, xx, yy, SFW'(fc)};
  endfunction

  // Model: mode 0 idle, 1 run, 2 stop; pos is the linear pixel index in the frame.
  int m_mode = 0, m_pos = 0, m_fc = 0;
  initial begin : model_cmp
    int o_mode, o_pos;
    bit last;
    logic [VW-1:0] req, act;
    forever begin
      tick();
      if (!rst_n) begin
        m_mode = 0; m_pos = 0; m_fc = 0;
        req = expect_vec(0, 0, 0);
      end else begin
        o_mode = m_mode;
        o_pos  = m_pos;
        last   = (m_pos == S_FT - 1);
        if (m_mode == 0) begin
          if (en_s) begin m_mode = 1; m_pos = 0; end
        end else begin
          if (last) begin m_pos = 0; m_fc = (m_fc + 1) % (1 << SFW); end
          else m_pos++;
          if (m_mode == 2) begin
            if (en_s) m_mode = 1;
            else if (last) m_mode = 0;
          end else if (!en_s) begin
            m_mode = 2;
          end
        end
        req = expect_vec(o_mode, o_pos, m_fc);
      end
      act = {s_hs, s_vs, s_de, s_ls, s_fs, s_run, s_x, s_y, s_fc};
      checks++;
      if (act !== req) begin
        errors++;
        $display("FAIL scan_cmp t=%0t: actual=%h required=%h", $time, act, req);
      end
    end
  end

  task automatic wait_fs(input string nm, output int n);
    n = 0;
    do begin tick(); n++; end while (!s_fs && n < 2000);
    checks++;
    if (!s_fs) begin
      errors++;
      $display("FAIL %s: frame_start timeout actual=0 required=1", nm);
    end
  endtask

  task automatic wait_xy(input int wx, input int wy, input string nm);
    int n;
    n = 0;
    while (!(s_run && s_x == wx && s_y == wy) && n < 2000) begin tick(); n++; end
    checks++;
    if (n >= 2000) begin
      errors++;
      $display("FAIL %s: position timeout actual=%0d,%0d required=%0d,%0d", nm, s_x, s_y, wx, wy);
    end
  endtask

  task automatic measure_frame(output int cyc, output int de_n, output int ls_n,
                               output int hs_x0, output int hs_len,
                               output int vs_y0, output int vs_len);
    cyc = 0; de_n = 0; ls_n = 0; hs_x0 = -1; hs_len = 0; vs_y0 = -1; vs_len = 0;
    do begin
      if (s_de) de_n++;
      if (s_ls) ls_n++;
      if (!s_hs) begin
        if (hs_x0 < 0) hs_x0 = int'(s_x);
        if (s_y == 0) hs_len++;
      end
      if (!s_vs) begin
        if (vs_y0 < 0) vs_y0 = int'(s_y);
        if (s_x == 0) vs_len++;
      end
      tick();
      cyc++;
    end while (!s_fs && cyc < 2000);
  endtask

  // Default-parameter instance: one full line after reset release with en=1.
  initial begin : dflt_line
    int c, nls, de_n, hs_x0, hs_len, vs_low;
    int ls_t[2];
    c = 0; nls = 0; de_n = 0; hs_x0 = -1; hs_len = 0; vs_low = 0;
    ls_t[0] = 0; ls_t[1] = 0;
    @(posedge rst_n_d);
    while (c < 2000 && nls < 2) begin
      tick();
      c++;
      if (d_ls) begin
        if (nls == 0) begin
          check("d_first_ls_fs", d_fs, 1);
          check("d_first_ls_xy", {d_x, d_y}, 0);
        end
        ls_t[nls] = c;
        nls++;
      end
      if (nls == 1) begin
        if (d_de) de_n++;
        if (!d_hs) begin
          if (hs_x0 < 0) hs_x0 = int'(d_x);
          hs_len++;
        end
        if (!d_vs) vs_low++;
      end
    end
    check("d_ls_count", nls, 2);
    check("d_ls_spacing", ls_t[1] - ls_t[0], 800);
    check("d_hs_start_x", hs_x0, 656);
    check("d_hs_len", hs_len, 96);
    check("d_de_per_line", de_n, 640);
    check("d_vs_line0", vs_low, 0);
    $display("txn default_line: ls_spacing=%0d hs_x=%0d hs_len=%0d", ls_t[1] - ls_t[0], hs_x0, hs_len);
    d_done = 1'b1;
  end

  initial begin : stim
    int n, cyc, de_n, ls_n, hs_x0, hs_len, vs_y0, vs_len, fc_before, px, py, t0, rl0;
    int fc_exp[4];
    fc_exp[0] = 2; fc_exp[1] = 3; fc_exp[2] = 0; fc_exp[3] = 1;

    repeat (3) tick();
    check("rst_hs", s_hs, 1);
    check("rst_vs", s_vs, 1);
    check("rst_de", s_de, 0);
    check("rst_xy", {s_x, s_y}, 0);
    check("rst_fc", s_fc, 0);
    check("rst_run", s_run, 0);
    check("d_rst_sync", {d_hs, d_vs, d_de, d_run}, 4'b1100);
    $display("txn reset: hs=%0b vs=%0b run=%0b", s_hs, s_vs, s_run);

    @(negedge clk); rst_n = 1'b1; rst_n_d = 1'b1;
    repeat (10) tick();
    check("idle_no_en_run", s_run, 0);
    check("idle_no_en_ls", s_ls, 0);
    $display("txn idle_hold: run=%0b", s_run);

    @(negedge clk); en_s = 1'b1;
    wait_fs("first_fs", n);
    check("en_to_fs_latency", n, 2);
    check("first_fs_xy", {s_x, s_y}, 0);
    check("first_fs_fc", s_fc, 0);
    measure_frame(cyc, de_n, ls_n, hs_x0, hs_len, vs_y0, vs_len);
    check("frame_len", cyc, S_FT);
    check("de_per_frame", de_n, S_HA * S_VA);
    check("ls_per_frame", ls_n, S_VT);
    check("hs_start_x", hs_x0, 10);
    check("hs_len", hs_len, 3);
    check("vs_start_y", vs_y0, 7);
    check("vs_lines", vs_len, 2);
    check("fc_seq0", s_fc, 1);
    $display("txn frame: len=%0d de=%0d hs_x=%0d vs_y=%0d", cyc, de_n, hs_x0, vs_y0);

    for (int k = 0; k < 4; k++) begin
      wait_fs("fc_seq_fs", n);
      check("fc_seq_spacing", n, S_FT);
      check("fc_seq", s_fc, fc_exp[k]);
      $display("txn fc_wrap: frame_cnt=%0d", s_fc);
    end

    wait_xy(0, 3, "stop_at_y3");
    fc_before = int'(s_fc);
    @(negedge clk); en_s = 1'b0;
    px = 0; py = 0; n = 0;
    while (s_run && n < 400) begin
      px = int'(s_x); py = int'(s_y);
      tick();
      n++;
    end
    check("stop_reaches_idle", s_run, 0);
    check("stop_last_x", px, S_HT - 1);
    check("stop_last_y", py, S_VT - 1);
    check("stop_fc_inc", s_fc, (fc_before + 1) % 4);
    check("stop_sync_high", {s_hs, s_vs, s_de}, 3'b110);
    repeat (5) tick();
    check("stop_stays_idle", {s_run, s_x, s_y}, 0);
    $display("txn stop: last=%0d,%0d frame_cnt=%0d", px, py, s_fc);

    @(negedge clk); en_s = 1'b1;
    wait_fs("restart_fs", n);
    check("restart_latency", n, 2);
    t0 = cyc_cnt;
    rl0 = run_low_cnt;
    wait_xy(0, 2, "pause_at_y2");
    @(negedge clk); en_s = 1'b0;
    wait_xy(0, 6, "resume_at_y6");
    @(negedge clk); en_s = 1'b1;
    wait_fs("resume_fs", n);
    check("resume_fs_spacing", cyc_cnt - t0, S_FT);
    check("resume_no_idle", run_low_cnt - rl0, 0);
    $display("txn pause_resume: spacing=%0d", cyc_cnt - t0);

    wait_xy(5, 4, "rst_at_x5y4");
    @(negedge clk); rst_n = 1'b0;
    #1;
    check("async_rst_sync", {s_hs, s_vs, s_de, s_ls, s_fs, s_run}, 6'b110000);
    check("async_rst_xy", {s_x, s_y}, 0);
    check("async_rst_fc", s_fc, 0);
    repeat (2) tick();
    @(negedge clk); rst_n = 1'b1;
    wait_fs("post_rst_fs", n);
    check("post_rst_latency", n, 2);
    check("post_rst_xy", {s_x, s_y}, 0);
    $display("txn mid_frame_reset: restart_latency=%0d", n);

    n = 0;
    while (!d_done && n < 3000) begin tick(); n++; end
    check("d_line_done", d_done, 1);
    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
